// File: rtl/gbf_fill_scheduler.sv
// -----------------------------------------------------------------------------
// gbf_fill_scheduler
//
// Purpose:
//   Shares one external fill port between the four double-buffered global
//   buffer banks (actv_gbf1, actv_gbf2, wgt_gbf1, wgt_gbf2). Level requests on
//   need_data are arbitrated round-robin. The winner's burst is requested from
//   the external source, and BURST_LEN beats are streamed into that bank with
//   incrementing addresses. A one-cycle per-bank completion pulse follows the
//   burst.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   need_data    [3:0] level requests (0 actv_gbf1, 1 actv_gbf2, 2 wgt_gbf1,
//                3 wgt_gbf2)
//   ext_req      burst request to the external source (held until ext_ack)
//   ext_req_id   [1:0] bank index of the outstanding request
//   ext_ack      source accepts the burst request
//   ext_valid    ext_data beat valid
//   ext_data     burst data beat
//   ext_ready    scheduler accepts a beat (high only while transferring)
//   gbf_w_en     [3:0] registered one-hot write strobe to the granted bank
//   gbf_w_addr   registered write address
//   gbf_w_data   registered write data
//   fill_done    [3:0] one-cycle one-hot completion pulse
//   busy         high in every state except IDLE
//
// Handshakes:
//   Request: ext_req/ext_req_id stay stable from entry into REQ until the cycle
//   that ext_ack is sampled high; ext_ack is ignored in all other states.
//   Data: a beat transfers on a rising edge where ext_valid && ext_ready;
//   ext_valid outside the transfer state never causes a write.
// -----------------------------------------------------------------------------
module gbf_fill_scheduler #(
    parameter int GBF_DATA_BITWIDTH = 256,
    parameter int GBF_ADDR_BITWIDTH = 5,
    parameter int BURST_LEN         = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   need_data,
    output logic                         ext_req,
    output logic [1:0]                   ext_req_id,
    input  logic                         ext_ack,
    input  logic                         ext_valid,
    input  logic [GBF_DATA_BITWIDTH-1:0] ext_data,
    output logic                         ext_ready,
    output logic [3:0]                   gbf_w_en,
    output logic [GBF_ADDR_BITWIDTH-1:0] gbf_w_addr,
    output logic [GBF_DATA_BITWIDTH-1:0] gbf_w_data,
    output logic [3:0]                   fill_done,
    output logic                         busy
);

    localparam logic [GBF_ADDR_BITWIDTH-1:0] LAST_ADDR =
        GBF_ADDR_BITWIDTH'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        XFER  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [1:0]                   rr_ptr;
    logic [1:0]                   grant;
    logic [3:0]                   grant_onehot;
    logic [3:0]                   done_mask;
    logic [3:0]                   eligible;
    logic [1:0]                   winner;
    logic                         winner_found;
    logic [GBF_ADDR_BITWIDTH-1:0] beat_cnt;
    logic                         beat;

    assign eligible     = need_data & ~done_mask;
    assign grant_onehot = 4'b0001 << grant;
    assign beat         = (state == XFER) && ext_valid;

    // Round-robin search starting one past the last winner, wrapping mod 4.
    // rr_ptr resets to 3 so the first search order is 0,1,2,3.
    always_comb begin
        winner       = 2'd0;
        winner_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!winner_found && eligible[rr_ptr + 2'(k)]) begin
                winner       = rr_ptr + 2'(k);
                winner_found = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control outputs.
    always_comb begin
        state_next = state;
        ext_req    = 1'b0;
        ext_req_id = 2'd0;
        ext_ready  = 1'b0;
        fill_done  = 4'b0000;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (winner_found) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                ext_req    = 1'b1;
                ext_req_id = grant;
                if (ext_ack) begin
                    state_next = XFER;
                end
            end
            XFER: begin
                ext_ready = 1'b1;
                if (ext_valid && (beat_cnt == LAST_ADDR)) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // The registered write of the final beat is on the bus now.
                state_next = DONE;
            end
            DONE: begin
                fill_done  = grant_onehot;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant latch and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant  <= 2'd0;
            rr_ptr <= 2'd3;
        end else if ((state == IDLE) && winner_found) begin
            grant  <= winner;
            rr_ptr <= winner;
        end
    end

    // A completed bank stays masked until it drops its level request, so a
    // bank that is slow to deassert need_data is not refilled twice.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_mask <= 4'b0000;
        end else begin
            done_mask <= (done_mask | fill_done) & need_data;
        end
    end

    // Beat counter: cleared on entry to XFER, advances once per accepted beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if ((state == REQ) && ext_ack) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Registered write port: one cycle behind the accepted beat. Address and
    // data hold their last value on idle cycles; only the strobe drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gbf_w_en   <= 4'b0000;
            gbf_w_addr <= '0;
            gbf_w_data <= '0;
        end else if (beat) begin
            gbf_w_en   <= grant_onehot;
            gbf_w_addr <= beat_cnt;
            gbf_w_data <= ext_data;
        end else begin
            gbf_w_en   <= 4'b0000;
        end
    end

endmodule

// File: tb/tb_gbf_fill_scheduler.sv
// -----------------------------------------------------------------------------
// tb_gbf_fill_scheduler
//
// Directed testbench for gbf_fill_scheduler with default parameters
// (256-bit data, 5-bit address, 32-beat bursts). Inputs are driven 1 ns after
// each rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_gbf_fill_scheduler;

    localparam int DW = 256;
    localparam int AW = 5;
    localparam int BL = 32;

    logic          clk;
    logic          reset;
    logic [3:0]    need_data;
    logic          ext_req;
    logic [1:0]    ext_req_id;
    logic          ext_ack;
    logic          ext_valid;
    logic [DW-1:0] ext_data;
    logic          ext_ready;
    logic [3:0]    gbf_w_en;
    logic [AW-1:0] gbf_w_addr;
    logic [DW-1:0] gbf_w_data;
    logic [3:0]    fill_done;
    logic          busy;

    int total = 0;
    int bad   = 0;

    gbf_fill_scheduler #(
        .GBF_DATA_BITWIDTH(DW),
        .GBF_ADDR_BITWIDTH(AW),
        .BURST_LEN        (BL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .need_data (need_data),
        .ext_req   (ext_req),
        .ext_req_id(ext_req_id),
        .ext_ack   (ext_ack),
        .ext_valid (ext_valid),
        .ext_data  (ext_data),
        .ext_ready (ext_ready),
        .gbf_w_en  (gbf_w_en),
        .gbf_w_addr(gbf_w_addr),
        .gbf_w_data(gbf_w_data),
        .fill_done (fill_done),
        .busy      (busy)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Driver / checker tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int bank, input int k);
        return (DW'(bank) << 200) | DW'(k);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ext_req"},    DW'(ext_req),    '0);
        chk({tag, ".ext_req_id"}, DW'(ext_req_id), '0);
        chk({tag, ".ext_ready"},  DW'(ext_ready),  '0);
        chk({tag, ".gbf_w_en"},   DW'(gbf_w_en),   '0);
        chk({tag, ".gbf_w_addr"}, DW'(gbf_w_addr), '0);
        chk({tag, ".gbf_w_data"}, gbf_w_data,      '0);
        chk({tag, ".fill_done"},  DW'(fill_done),  '0);
        chk({tag, ".busy"},       DW'(busy),       '0);
    endtask

    // Entered with the DUT observed in REQ for `bank`. Holds off ext_ack for
    // ack_delay cycles, streams BL beats (optionally every other cycle), and
    // checks every write, the flush cycle, the done pulse and the return to
    // IDLE.
    task automatic do_fill(input int bank, input int ack_delay, input bit toggle);
        int beat_n;
        int cyc;
        bit v;
        for (int i = 0; i < ack_delay; i++) begin
            chk("req_hold", DW'(ext_req), DW'(1));
            chk("req_hold_id", DW'(ext_req_id), DW'(bank));
            chk("req_busy", DW'(busy), DW'(1));
            tick();
        end
        chk("req", DW'(ext_req), DW'(1));
        chk("req_id", DW'(ext_req_id), DW'(bank));
        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        chk("xfer_ready", DW'(ext_ready), DW'(1));
        chk("xfer_req_low", DW'(ext_req), DW'(0));
        beat_n = 0;
        cyc    = 0;
        while (beat_n < BL && cyc < 200) begin
            v = toggle ? ((cyc % 2) == 0) : 1'b1;
            ext_valid = v;
            ext_data  = v ? beat_data(bank, beat_n) : '1;
            tick();
            if (v) begin
                chk("w_en", DW'(gbf_w_en), DW'(4'b0001 << bank));
                chk("w_addr", DW'(gbf_w_addr), DW'(beat_n));
                chk("w_data", gbf_w_data, beat_data(bank, beat_n));
                beat_n++;
            end else begin
                chk("w_en_idle", DW'(gbf_w_en), '0);
            end
            chk("busy_xfer", DW'(busy), DW'(1));
            chk("no_done_xfer", DW'(fill_done), '0);
            cyc++;
        end
        chk("beat_count", DW'(beat_n), DW'(BL));
        ext_valid = 1'b0;
        ext_data  = '0;
        chk("flush_ready_low", DW'(ext_ready), DW'(0));
        tick();
        chk("fill_done", DW'(fill_done), DW'(4'b0001 << bank));
        chk("done_no_w_en", DW'(gbf_w_en), '0);
        chk("done_busy", DW'(busy), DW'(1));
        tick();
        chk("idle_done_low", DW'(fill_done), '0);
        chk("idle_busy", DW'(busy), DW'(0));
    endtask

    // Directed sequence
    initial begin
        reset     = 1'b1;
        need_data = 4'b0000;
        ext_ack   = 1'b0;
        ext_valid = 1'b0;
        ext_data  = '0;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Stray ext_valid / ext_ack while IDLE.
        ext_valid = 1'b1;
        ext_ack   = 1'b1;
        ext_data  = '1;
        tick();
        chk("stray_w_en", DW'(gbf_w_en), '0);
        chk("stray_busy", DW'(busy), DW'(0));
        chk("stray_req", DW'(ext_req), DW'(0));
        ext_valid = 1'b0;
        ext_ack   = 1'b0;
        ext_data  = '0;

        // Single request with one-cycle request latency.
        need_data = 4'b0001;
        tick();
        do_fill(0, 0, 1'b0);
        // need_data[0] still high: masked, no re-grant.
        tick();
        chk("no_regrant_a", DW'(ext_req), DW'(0));
        tick();
        chk("no_regrant_b", DW'(busy), DW'(0));
        need_data = 4'b0000;
        tick();
        need_data = 4'b0001;
        tick();
        chk("regrant", DW'(ext_req), DW'(1));
        // Dropping the request after grant does not abort the burst.
        need_data = 4'b0000;
        do_fill(0, 0, 1'b0);
        tick();
        chk("no_regrant_dropped", DW'(ext_req), DW'(0));

        // Simultaneous banks 0 and 2 after reset: 0 first, then 2.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        need_data = 4'b0101;
        tick();
        do_fill(0, 0, 1'b0);
        tick();
        do_fill(2, 0, 1'b0);
        need_data = 4'b0000;
        tick();
        chk("pair_idle", DW'(busy), DW'(0));

        // Fairness over eight fills with all four requesting.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        need_data = 4'b1111;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("fair_order", DW'(ext_req_id), DW'(i % 4));
            do_fill(i % 4, 0, 1'b0);
            if (i == 7) need_data = 4'b0000;
            else        need_data[i % 4] = 1'b0;
            tick();
            need_data[i % 4] = (i != 7);
        end
        chk("fair_idle", DW'(busy), DW'(0));

        // Backpressure: late ack, alternating valid.
        need_data = 4'b1000;
        tick();
        do_fill(3, 5, 1'b1);
        need_data = 4'b0000;
        tick();

        // Reset in the middle of a bank1 burst.
        need_data = 4'b0010;
        tick();
        chk("mid_req_id", DW'(ext_req_id), DW'(1));
        ext_ack = 1'b1;
        tick();
        ext_ack = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            ext_valid = 1'b1;
            ext_data  = beat_data(1, k);
            tick();
            chk("mid_addr", DW'(gbf_w_addr), DW'(k));
        end
        ext_valid = 1'b0;
        reset     = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        tick();
        chk("mid_reset_no_done", DW'(fill_done), '0);
        reset = 1'b0;
        tick();
        do_fill(1, 0, 1'b0);
        need_data = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gbf_fill_scheduler.md
Name: gbf_fill_scheduler

Overview:
- Shares one external fill port between the four double-buffered global buffer banks: actv_gbf1, actv_gbf2, wgt_gbf1, wgt_gbf2.
- Arbitrates their need_data requests round-robin and handshakes a burst with the external source.
- Streams BURST_LEN words into the granted bank with incrementing addresses, then pulses a per-bank completion.

Parameters:
GBF_DATA_BITWIDTH, 256, width of one GBF word / external data beat
GBF_ADDR_BITWIDTH, 5, GBF write address width
BURST_LEN, 32, words per fill; must be ≤ 2^GBF_ADDR_BITWIDTH and ≥ 1

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
need_data  input  4  level requests; bit0 actv_gbf1, bit1 actv_gbf2, bit2 wgt_gbf1, bit3 wgt_gbf2
ext_req  output  1  burst request to external source
ext_req_id  output  2  index of bank being requested
ext_ack  input  1  source accepts burst request
ext_valid  input  1  ext_data beat valid
ext_data  input  GBF_DATA_BITWIDTH  burst data beat
ext_ready  output  1  scheduler accepts beat
gbf_w_en  output  4  one-hot write strobe to granted bank (registered)
gbf_w_addr  output  GBF_ADDR_BITWIDTH  write address (registered)
gbf_w_data  output  GBF_DATA_BITWIDTH  write data (registered)
fill_done  output  4  one-cycle one-hot completion pulse
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async): state IDLE; rr_ptr=3; beat counter=0; done_mask=0. All outputs are 0, including gbf_w_data and gbf_w_addr.
- Eligibility: eligible = need_data & ~done_mask.
  - done_mask[i] sets at fill_done[i].
  - done_mask[i] clears on any cycle need_data[i]=0.
  - This prevents a bank from being re-granted before it drops its level request.
- Round-robin: search eligible from rr_ptr+1 upward, mod 4; the first hit wins. rr_ptr updates to the winner on grant. After reset, priority order is 0,1,2,3.
- FSM states: IDLE, REQ, XFER, FLUSH, DONE.
  - IDLE: if eligible≠0, latch grant and go to REQ next cycle. Otherwise stay in IDLE.
  - REQ: ext_req=1 and ext_req_id=grant, held stable until ext_ack. On a cycle with ext_ack=1, go to XFER next cycle with counter=0. There is no timeout.
  - XFER: ext_ready=1.
    - Each cycle with ext_valid&ext_ready is one beat. One cycle later: gbf_w_en[grant]=1, gbf_w_addr=counter value of that beat, gbf_w_data=ext_data of that beat. Then counter increments.
    - Cycles with ext_valid=0 give gbf_w_en=0 next cycle; counter holds.
    - The beat with counter=BURST_LEN-1 moves to FLUSH; ext_ready drops in FLUSH.
  - FLUSH: one cycle; the last write strobe is visible. Go to DONE.
  - DONE: one cycle; fill_done[grant]=1. Return to IDLE. Arbitration restarts in the IDLE cycle that follows.
- Latency: from need_data rising (IDLE, rr favourable) to ext_req is 1 cycle. With ext_valid held high, last write to fill_done is 1 cycle. Minimum gap between consecutive ext_req bursts is 3 cycles (DONE, IDLE, REQ).
- need_data[grant] falling after grant does not abort. The burst completes, and done_mask for that bit clears immediately because need_data is low.
- ext_valid while not in XFER is ignored; no write occurs. ext_ack outside REQ is ignored.
- Counter width is GBF_ADDR_BITWIDTH. When BURST_LEN = 2^GBF_ADDR_BITWIDTH, the last address is all-ones. The counter resets to 0 at each XFER entry and never wraps mid-burst.
- Reset asserted mid-burst: immediate return to reset values. The partial fill is abandoned with no fill_done. A still-high need_data is re-arbitrated from priority 0 after reset release.
- gbf_w_en is at most one-hot. fill_done is at most one-hot and never coincides with gbf_w_en.

Test Plan:
1. Single request: need_data=0001, ack on first REQ cycle, 32 back-to-back beats with data=k.
   - Expected: gbf_w_en=0001 for 32 consecutive cycles, addr 0..31, data 0..31.
   - fill_done=0001 exactly one cycle after the last strobe. No re-grant while need_data[0] stays high; re-grant after it toggles low then high.
2. Simultaneous need_data=0101 after reset: bank0 served first, then bank2 (ext_req_id 0 then 2). Each gets 32 writes and its own fill_done pulse.
3. Fairness: all four held high (dropping and re-raising after each done) for 8 fills → grant order 0,1,2,3,0,1,2,3.
4. Backpressure: ext_ack delayed 5 cycles, ext_valid toggling 1,0,1,0.
   - ext_req held stable 6 cycles. Exactly 32 strobes with contiguous addresses 0..31 and no strobe on idle cycles. busy=1 throughout.
5. Reset mid-burst: reset pulsed after beat 10 of bank1.
   - All outputs 0 in that cycle; no fill_done. After release with need_data=0010 held, a new burst to bank1 starts at address 0.
6. Stray inputs: ext_valid and ext_ack pulsed while in IDLE → no gbf_w_en, no state change.
